// File: rtl/aap_fetch.sv
// AAP instruction fetch stage: pulls 16-bit halfwords from instruction
// memory, assembles 16/32-bit instructions and hands them to decode.
module aap_fetch #(
    parameter int                  PC_WIDTH = 24,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic [31:0]         fetchoutput,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                fetch_is32,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    typedef enum logic [2:0] {
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                drop_q, drop_d;
    logic [15:0]         lo_q, lo_d;
    logic [31:0]         out_q, out_d;
    logic [PC_WIDTH-1:0] fpc_q, fpc_d;
    logic                is32_q, is32_d;
    logic                valid_q, valid_d;

    logic                req_c;
    logic                waiting;
    logic [PC_WIDTH-1:0] pc_hi;
    logic [PC_WIDTH-1:0] pc_step;

    assign waiting = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    assign pc_hi   = pc_q + PC_WIDTH'(1);
    assign pc_step = {{(PC_WIDTH-2){1'b0}}, is32_q, ~is32_q};

    // A stale response must drain before a new request may go out.
    assign req_c = ((state_q == ISSUE_LO) && !drop_q) || (state_q == ISSUE_HI);

    // Request strobe and address; held at zero while reset is asserted.
    always_comb begin
        imem_req  = reset & req_c;
        imem_addr = '0;
        if (imem_req) begin
            imem_addr = (state_q == ISSUE_HI) ? pc_hi : pc_q;
        end
    end

    assign fetchoutput = out_q;
    assign fetch_pc    = fpc_q;
    assign fetch_is32  = is32_q;
    assign fetch_valid = valid_q;

    // Next-state, pc and decode-bundle logic; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        lo_d    = lo_q;
        out_d   = out_q;
        fpc_d   = fpc_q;
        is32_d  = is32_q;
        valid_d = valid_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = ISSUE_LO;
            if (waiting) begin
                drop_d = !imem_ack;
            end else if (req_c) begin
                drop_d = 1'b1;
            end else if (drop_q && imem_ack) begin
                drop_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                ISSUE_LO: begin
                    if (drop_q) begin
                        if (imem_ack) drop_d = 1'b0;
                    end else begin
                        state_d = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (imem_ack) begin
                        lo_d = imem_rdata;
                        if (!imem_rdata[15]) begin
                            out_d   = {16'h0, imem_rdata};
                            fpc_d   = pc_q;
                            is32_d  = 1'b0;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end else begin
                            state_d = ISSUE_HI;
                        end
                    end
                end
                ISSUE_HI: begin
                    state_d = WAIT_HI;
                end
                WAIT_HI: begin
                    if (imem_ack) begin
                        out_d   = {imem_rdata, lo_q};
                        fpc_d   = pc_q;
                        is32_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (valid_q && fetch_ready) begin
                        pc_d    = pc_q + pc_step;
                        valid_d = 1'b0;
                        state_d = ISSUE_LO;
                    end
                end
                default: state_d = ISSUE_LO;
            endcase
        end
    end

    // State register; reset remembers a request left in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ISSUE_LO;
            pc_q    <= RESET_PC;
            drop_q  <= waiting && !imem_ack;
            lo_q    <= '0;
            out_q   <= '0;
            fpc_q   <= '0;
            is32_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
            fpc_q   <= fpc_d;
            is32_q  <= is32_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_aap_fetch.sv
// Bench for aap_fetch: latency-programmable memory, instruction-stream
// model checked every cycle, plus directed literal checks.
module tb_aap_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [31:0] fetchoutput;
    logic [23:0] fetch_pc;
    logic        fetch_is32;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [23:0] redirect_pc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem [logic [23:0]];
    int          lat = 1;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [23:0] paddr;
    logic [23:0] req_log [$];
    logic [23:0] model_pc = '0;

    aap_fetch #(.PC_WIDTH(24), .RESET_PC(24'h0)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .fetchoutput   (fetchoutput),
        .fetch_pc      (fetch_pc),
        .fetch_is32    (fetch_is32),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] rd(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : 16'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!imem_req && k < 60) begin
            tick();
            k++;
        end
        chk("wait_req", {31'b0, imem_req}, 1);
    endtask

    task automatic wait_req_addr(input logic [23:0] a);
        int k = 0;
        while (!(imem_req && imem_addr == a) && k < 200) begin
            tick();
            k++;
        end
        chk("wait_req_addr", {8'b0, imem_addr}, {8'b0, a});
    endtask

    task automatic wait_valid_pc(input logic [23:0] a);
        int k = 0;
        while (!(fetch_valid && fetch_pc == a) && k < 200) begin
            tick();
            k++;
        end
        chk("wait_valid_pc", {8'b0, fetch_pc}, {8'b0, a});
    endtask

    // Memory: one response per accepted request after lat cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clock);
            imem_ack = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = rd(paddr);
                    pending    = 1'b0;
                end
            end
            if (imem_req) begin
                chk("one_outstanding", {31'b0, pending}, 0);
                pending = 1'b1;
                cnt     = lat;
                paddr   = imem_addr;
                req_log.push_back(imem_addr);
            end
        end
    end

    // Instruction-stream model: decode must see mem in program order.
    initial begin
        logic [15:0] h0;
        logic [15:0] h1;
        logic [31:0] exp;
        logic        e32;
        forever begin
            @(negedge clock);
            if (!reset) begin
                model_pc = 24'h0;
            end else begin
                if (imem_req) begin
                    chk("req_addr",
                        {31'b0, (imem_addr == model_pc) ||
                                (imem_addr == model_pc + 24'd1)}, 1);
                end
                if (fetch_valid) begin
                    h0  = rd(model_pc);
                    h1  = rd(model_pc + 24'd1);
                    e32 = h0[15];
                    exp = e32 ? {h1, h0} : {16'h0, h0};
                    chk("model_out", fetchoutput, exp);
                    chk("model_pc", {8'b0, fetch_pc}, {8'b0, model_pc});
                    chk("model_is32", {31'b0, fetch_is32}, {31'b0, e32});
                    if (fetch_ready && !redirect_valid) begin
                        model_pc = model_pc + (e32 ? 24'd2 : 24'd1);
                    end
                end
                if (redirect_valid) model_pc = redirect_pc;
            end
        end
    end

    initial begin
        logic [23:0] r;
        mem[24'h000000] = 16'h0123;
        mem[24'h000001] = 16'h0456;
        mem[24'h000002] = 16'h0789;
        mem[24'h000003] = 16'h0ABC;
        mem[24'h000004] = 16'h8001;
        mem[24'h000005] = 16'hABCD;
        mem[24'h000006] = 16'h1111;
        mem[24'h000007] = 16'h2222;
        mem[24'h000008] = 16'h3333;
        mem[24'h000100] = 16'h0AAA;
        mem[24'h000101] = 16'h0BBB;
        mem[24'hFFFFFF] = 16'h8000;
        reset          = 1'b0;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        tick();
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_valid", {31'b0, fetch_valid}, 0);
        chk("rst_out", fetchoutput, 0);
        chk("rst_pc", {8'b0, fetch_pc}, 0);
        chk("rst_is32", {31'b0, fetch_is32}, 0);

        reset = 1'b1;
        #1;
        chk("first_req", {31'b0, imem_req}, 1);
        chk("first_addr", {8'b0, imem_addr}, 0);
        tick();
        chk("lat_wait", {31'b0, fetch_valid}, 0);
        tick();
        chk("lat_valid", {31'b0, fetch_valid}, 1);
        chk("i0_out", fetchoutput, 32'h00000123);
        chk("i0_pc", {8'b0, fetch_pc}, 0);
        chk("i0_is32", {31'b0, fetch_is32}, 0);
        tick();
        chk("i1_req", {31'b0, imem_req}, 1);
        chk("i1_addr", {8'b0, imem_addr}, 1);

        wait_valid_pc(24'd4);
        chk("i4_out", fetchoutput, 32'hABCD8001);
        chk("i4_is32", {31'b0, fetch_is32}, 1);
        r = req_log[req_log.size()-2];
        chk("i4_req_lo", {8'b0, r}, 4);
        r = req_log[req_log.size()-1];
        chk("i4_req_hi", {8'b0, r}, 5);
        tick();
        chk("i6_addr", {8'b0, imem_addr}, 6);

        fetch_ready = 1'b0;
        wait_valid_pc(24'd6);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out", fetchoutput, 32'h00001111);
            chk("stall_valid", {31'b0, fetch_valid}, 1);
            chk("stall_req", {31'b0, imem_req}, 0);
        end
        fetch_ready = 1'b1;
        tick();
        chk("after_stall_req", {31'b0, imem_req}, 1);
        chk("after_stall_addr", {8'b0, imem_addr}, 7);

        lat = 3;
        wait_req_addr(24'd8);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 24'h000100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_req0", {31'b0, imem_req}, 0);
        tick();
        chk("drop_req1", {31'b0, imem_req}, 0);
        wait_req();
        chk("redir_addr", {8'b0, imem_addr}, 24'h000100);
        wait_valid_pc(24'h000100);
        chk("redir_out", fetchoutput, 32'h00000AAA);

        redirect_valid = 1'b1;
        redirect_pc    = 24'hFFFFFF;
        tick();
        redirect_valid = 1'b0;
        wait_req();
        chk("wrap_lo", {8'b0, imem_addr}, 24'hFFFFFF);
        tick();
        wait_req();
        chk("wrap_hi", {8'b0, imem_addr}, 0);
        wait_valid_pc(24'hFFFFFF);
        chk("wrap_out", fetchoutput, 32'h01238000);
        chk("wrap_is32", {31'b0, fetch_is32}, 1);
        tick();
        wait_req();
        chk("wrap_next", {8'b0, imem_addr}, 1);

        wait_req_addr(24'd5);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_req", {31'b0, imem_req}, 0);
        chk("mid_rst_addr", {8'b0, imem_addr}, 0);
        chk("mid_rst_valid", {31'b0, fetch_valid}, 0);
        chk("mid_rst_out", fetchoutput, 0);
        chk("mid_rst_pc", {8'b0, fetch_pc}, 0);
        chk("mid_rst_is32", {31'b0, fetch_is32}, 0);
        reset = 1'b1;
        #1;
        chk("late_ack_req", {31'b0, imem_req}, 0);
        wait_req();
        chk("rst_pc_req", {8'b0, imem_addr}, 0);
        chk("late_ack_gone", {31'b0, pending}, 0);
        wait_valid_pc(24'd0);
        chk("rst_out2", fetchoutput, 32'h00000123);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
